// File: rtl/riscv_test_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_test_pkg
// Description : Shared types and constants for the riscv-tests monitor:
//               run-sequencer state encoding, verdict encoding and the
//               tohost mailbox decode rule.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_test_pkg;

  // Run sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Verdict produced by one RUN cycle
  typedef enum logic [2:0] {
    VERDICT_NONE    = 3'd0,
    VERDICT_PASS    = 3'd1,
    VERDICT_FAIL    = 3'd2,
    VERDICT_HANG    = 3'd3,
    VERDICT_TIMEOUT = 3'd4
  } verdict_e;

  // tohost value written by the riscv-tests pass macro
  localparam int unsigned TOHOST_PASS = 1;

  // riscv-tests tohost rule: bit 0 set means "test result" (1 = pass,
  // any other odd value = fail with TESTNUM in the upper bits); bit 0 clear
  // with a nonzero value is a syscall request and does not end the test.
  function automatic verdict_e tohost_decode(input logic is_pass_value,
                                             input logic wdata_lsb);
    if (is_pass_value) begin
      return VERDICT_PASS;
    end else if (wdata_lsb) begin
      return VERDICT_FAIL;
    end else begin
      return VERDICT_NONE;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_test_monitor_if.sv
`default_nettype none
// ============================================================================
// Interface   : riscv_test_monitor_if
// Description : Signals between the Core under test and the test monitor.
//   core_rst   monitor -> core  active-high core reset
//   mem_we     core -> monitor  data-memory write enable
//   mem_addr   core -> monitor  data-memory write byte address
//   mem_wdata  core -> monitor  data-memory write data
//   pc         core -> monitor  current program counter
//   retire     core -> monitor  one instruction retired this cycle
//   Modports: master = Core side, slave = monitor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_test_monitor_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              core_rst;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] pc;
  logic              retire;

  modport master (
    output mem_we, mem_addr, mem_wdata, pc, retire,
    input  core_rst
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata, pc, retire,
    output core_rst
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones. Clear wins over enable.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   clr_i  in   synchronous clear to 0
//   en_i   in   count enable
//   cnt_o  out  current count (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ============================================================================
// Module      : riscv_test_monitor
// Description : riscv-tests harness companion. Sequences Core reset, snoops
//               data-memory writes for the tohost mailbox and latches a
//               pass / fail / hang / timeout verdict with cycle and retired
//               instruction counts.
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   start      in   begin a run (accepted in IDLE or DONE)
//   core_if    slave modport: core_rst out, mem_we/mem_addr/mem_wdata/pc/
//              retire in
//   done       out  verdict valid, held until next start or reset
//   pass       out  tohost == 1 received
//   fail       out  odd tohost != 1 received
//   fail_code  out  failing tohost value >> 1 (TESTNUM)
//   hang       out  pc stalled for HANG_CYCLES cycles
//   timeout    out  RUN lasted TIMEOUT_CYCLES cycles
//   cycles     out  RUN cycles elapsed, saturating
//   retired    out  retire pulses seen in RUN, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_test_monitor
  import riscv_test_pkg::*;
#(
  parameter int unsigned       ADDR_W         = 32,
  parameter int unsigned       DATA_W         = 32,
  parameter int unsigned       CNT_W          = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int unsigned       RESET_CYCLES   = 4,
  parameter int unsigned       TIMEOUT_CYCLES = 5000,
  parameter int unsigned       HANG_CYCLES    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  riscv_test_monitor_if.slave  core_if,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [DATA_W-2:0]    fail_code,
  output logic                 hang,
  output logic                 timeout,
  output logic [CNT_W-1:0]     cycles,
  output logic [CNT_W-1:0]     retired
);

  // Hold counter runs 0 .. RESET_CYCLES-1 while in HOLD
  localparam int unsigned       HOLD_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  // Verdicts fire in the cycle whose closing edge makes the count reach the limit
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  HANG_LAST    = CNT_W'(HANG_CYCLES - 1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (RESET_CYCLES < 1) begin : g_chk_reset_cycles
    $error("riscv_test_monitor: RESET_CYCLES must be at least 1");
  end
  if ((64'(TIMEOUT_CYCLES) >> CNT_W) != 64'd0) begin : g_chk_timeout_fit
    $error("riscv_test_monitor: TIMEOUT_CYCLES does not fit in CNT_W bits");
  end
  if ((64'(HANG_CYCLES) >> CNT_W) != 64'd0) begin : g_chk_hang_fit
    $error("riscv_test_monitor: HANG_CYCLES does not fit in CNT_W bits");
  end
  if (DATA_W < 2) begin : g_chk_data_w
    $error("riscv_test_monitor: DATA_W must be at least 2");
  end

  // --------------------------------------------------------------------------
  // Registered state and outputs
  // --------------------------------------------------------------------------
  state_e            state_q;
  logic              core_rst_q;
  logic              done_q;
  logic              pass_q;
  logic              fail_q;
  logic              hang_q;
  logic              timeout_q;
  logic [DATA_W-2:0] fail_code_q;
  logic [ADDR_W-1:0] pc_prev_q;
  logic              first_run_q;   // high during the first RUN cycle only

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  logic w_start_ok;
  logic w_in_run;
  logic w_in_hold;
  logic w_pc_changed;

  assign w_start_ok   = start && ((state_q == IDLE) || (state_q == DONE));
  assign w_in_run     = (state_q == RUN);
  assign w_in_hold    = (state_q == HOLD);
  // pc_prev_q is stale on entry to RUN, so the first RUN cycle is forced to
  // look like a change and the stall count starts from zero.
  assign w_pc_changed = first_run_q || (core_if.pc != pc_prev_q);

  // --------------------------------------------------------------------------
  // Counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  w_cycle_cnt;
  logic [CNT_W-1:0]  w_retire_cnt;
  logic [CNT_W-1:0]  w_stall_cnt;
  logic [HOLD_W-1:0] w_hold_cnt;

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (w_start_ok),
    .en_i  (w_in_run),
    .cnt_o (w_cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (w_start_ok),
    .en_i  (w_in_run && core_if.retire),
    .cnt_o (w_retire_cnt)
  );

  // Counts consecutive cycles whose pc equals the previous cycle's pc
  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (w_start_ok || (w_in_run && w_pc_changed)),
    .en_i  (w_in_run && !w_pc_changed),
    .cnt_o (w_stall_cnt)
  );

  sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (w_start_ok),
    .en_i  (w_in_hold),
    .cnt_o (w_hold_cnt)
  );

  // --------------------------------------------------------------------------
  // Verdict detection (only consumed in RUN)
  // --------------------------------------------------------------------------
  logic     w_tohost;
  verdict_e w_tohost_verdict;
  logic     w_hang_hit;
  logic     w_timeout_hit;
  verdict_e w_verdict;

  assign w_tohost = core_if.mem_we
                 && (core_if.mem_addr == TOHOST_ADDR)
                 && (core_if.mem_wdata != '0);

  assign w_tohost_verdict = w_tohost
      ? tohost_decode(core_if.mem_wdata == DATA_W'(TOHOST_PASS), core_if.mem_wdata[0])
      : VERDICT_NONE;

  assign w_hang_hit    = (HANG_CYCLES != 0) && !w_pc_changed && (w_stall_cnt == HANG_LAST);
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (w_cycle_cnt == TIMEOUT_LAST);

  // tohost result outranks hang, which outranks timeout
  always_comb begin
    w_verdict = VERDICT_NONE;
    if (w_tohost_verdict != VERDICT_NONE) begin
      w_verdict = w_tohost_verdict;
    end else if (w_hang_hit) begin
      w_verdict = VERDICT_HANG;
    end else if (w_timeout_hit) begin
      w_verdict = VERDICT_TIMEOUT;
    end
  end

  // --------------------------------------------------------------------------
  // Run sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      hang_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      pc_prev_q   <= '0;
      first_run_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= HOLD;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            hang_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_code_q <= '0;
          end
        end

        HOLD: begin
          if (w_hold_cnt == HOLD_LAST) begin
            state_q     <= RUN;
            core_rst_q  <= 1'b0;
            first_run_q <= 1'b1;
          end
        end

        RUN: begin
          first_run_q <= 1'b0;
          pc_prev_q   <= core_if.pc;
          if (w_verdict != VERDICT_NONE) begin
            state_q    <= DONE;
            core_rst_q <= 1'b1;
            done_q     <= 1'b1;
            case (w_verdict)
              VERDICT_PASS: pass_q <= 1'b1;
              VERDICT_FAIL: begin
                fail_q      <= 1'b1;
                fail_code_q <= core_if.mem_wdata[DATA_W-1:1];
              end
              VERDICT_HANG:    hang_q    <= 1'b1;
              VERDICT_TIMEOUT: timeout_q <= 1'b1;
              default: ;
            endcase
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign core_if.core_rst = core_rst_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign fail             = fail_q;
  assign hang             = hang_q;
  assign timeout          = timeout_q;
  assign fail_code        = fail_code_q;
  assign cycles           = w_cycle_cnt;
  assign retired          = w_retire_cnt;

endmodule
`default_nettype wire
